// File: rtl/video_in_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_in_pkg
// Description : Shared types and constants for the video-in DMA writer:
//               capture FSM state encoding, default frame/burst/FIFO sizes
//               and the Wishbone full-word byte-select value.
// Revision    : 1.0 - initial release
// ============================================================================
package video_in_pkg;

  // Capture FSM states, explicitly 2 bits wide
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_CAPTURE  = 2'd2,
    ST_DRAIN    = 2'd3
  } vin_state_t;

  // 640x480 8-bit pixels packed four per 32-bit word
  localparam int c_DEF_FRAME_WORDS = 76800;
  localparam int c_DEF_BURST_LEN   = 8;
  localparam int c_DEF_FIFO_DEPTH  = 16;

  // All four byte lanes written on every transfer
  localparam logic [3:0] c_SEL_ALL = 4'hF;

endpackage
`default_nettype wire

// File: rtl/video_in_word_fifo.sv
`default_nettype none
// ============================================================================
// Module      : video_in_word_fifo
// Description : Synchronous single-clock FIFO with occupancy count. A push
//               and a pop in the same cycle both succeed even when full,
//               because the pop frees the slot first. Flush empties it.
// Revision    : 1.0 - initial release
// ============================================================================
module video_in_word_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                       p_clk,
  input  logic                       p_resetn,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge p_clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally for power-of-2 depth
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/video_in_dma_writer.sv
`default_nettype none
// ============================================================================
// Module      : video_in_dma_writer
// Description : Captures one 8-bit video frame, packs four pixels per 32-bit
//               word and writes the words to memory through a Wishbone
//               master using bursts of up to BURST_LEN transfers. Each FIFO
//               entry carries its own write address, so a word dropped on
//               overflow leaves its address hole untouched.
// Revision    : 1.0 - initial release
// ============================================================================
module video_in_dma_writer
  import video_in_pkg::*;
#(
  parameter int FRAME_WORDS = c_DEF_FRAME_WORDS,
  parameter int BURST_LEN   = c_DEF_BURST_LEN,
  parameter int FIFO_DEPTH  = c_DEF_FIFO_DEPTH
) (
  input  logic        p_clk,
  input  logic        p_resetn,
  input  logic [31:0] cfg_base_addr,
  input  logic        cfg_start,
  input  logic        pix_valid,
  input  logic        pix_sof,
  input  logic [7:0]  pix_data,
  output logic [31:0] p_wb_ADR_O,
  output logic [31:0] p_wb_DAT_O,
  input  logic [31:0] p_wb_DAT_I,
  output logic [3:0]  p_wb_SEL_O,
  output logic        p_wb_CYC_O,
  output logic        p_wb_STB_O,
  output logic        p_wb_WE_O,
  input  logic        p_wb_ACK_I,
  input  logic        p_wb_ERR_I,
  input  logic        p_wb_RTY_I,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        bus_err
);

  localparam int IDXW  = $clog2(FRAME_WORDS + 1);
  localparam int BEATW = $clog2(BURST_LEN + 1);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

  localparam logic [IDXW-1:0]  c_LAST_IDX  = IDXW'(FRAME_WORDS - 1);
  localparam logic [BEATW-1:0] c_LAST_BEAT = BEATW'(BURST_LEN - 1);
  localparam logic [FCW-1:0]   c_BURST_CNT = FCW'(BURST_LEN);

  // FSM
  vin_state_t r_state;
  vin_state_t w_state_next;
  logic       w_busy;
  logic       w_finish;

  // Capture / packer
  logic [31:0]     r_base;
  logic [IDXW-1:0] r_cap_idx;
  logic [1:0]      r_byte_cnt;
  logic [23:0]     r_pack;
  logic            r_word_vld;
  logic [31:0]     r_word_dat;
  logic [31:0]     r_word_adr;
  logic [31:0]     w_idx_ext;
  logic [31:0]     w_word_adr;

  // Status
  logic r_overflow;
  logic r_bus_err;
  logic r_done;

  // Bus writer
  logic             r_cyc;
  logic             r_resume;
  logic [BEATW-1:0] r_beats;

  // FIFO
  logic [63:0]    w_head;
  logic [FCW-1:0] w_fifo_count;
  logic           w_fifo_full;
  logic           w_fifo_empty;

  // Event decode
  logic w_start_accept;
  logic w_sof_take;
  logic w_pix_take;
  logic w_word_done;
  logic w_err;
  logic w_ack;
  logic w_rty;
  logic w_drop;
  logic w_last_beat;
  logic w_start_cyc;
  logic w_drain_done;
  logic w_unused_dat_i;

  assign w_unused_dat_i = ^p_wb_DAT_I;

  assign w_start_accept = cfg_start && (r_state == ST_IDLE);
  assign w_sof_take     = pix_valid && pix_sof && (r_state == ST_WAIT_SOF);
  assign w_pix_take     = pix_valid && (r_state == ST_CAPTURE);
  assign w_word_done    = w_pix_take && (r_byte_cnt == 2'd3);

  // ERR outranks ACK, ACK outranks RTY when a slave asserts several
  assign w_err = r_cyc && p_wb_ERR_I;
  assign w_ack = r_cyc && !p_wb_ERR_I && p_wb_ACK_I;
  assign w_rty = r_cyc && !p_wb_ERR_I && !p_wb_ACK_I && p_wb_RTY_I;

  // A pending word is lost only if the FIFO is full and nothing pops now
  assign w_drop = r_word_vld && w_fifo_full && !w_ack && !w_err;

  // Burst ends on its last beat or when the popped word was the only one
  assign w_last_beat = (r_beats == c_LAST_BEAT) ||
                       ((w_fifo_count == FCW'(1)) && !r_word_vld);

  assign w_start_cyc = !r_cyc && !w_fifo_empty &&
                       (r_resume || (w_fifo_count >= c_BURST_CNT) ||
                        (r_state == ST_DRAIN));

  assign w_drain_done = w_fifo_empty && !r_cyc && !r_word_vld && !r_resume;

  assign w_idx_ext  = 32'(r_cap_idx);
  assign w_word_adr = r_base + (w_idx_ext << 2);

  // State register
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) r_state <= ST_IDLE;
    else           r_state <= w_state_next;
  end

  // Next-state logic; a bus error aborts the frame from any state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (cfg_start)  w_state_next = ST_WAIT_SOF;
      ST_WAIT_SOF: if (w_sof_take) w_state_next = ST_CAPTURE;
      ST_CAPTURE:  if (w_word_done && (r_cap_idx == c_LAST_IDX))
                     w_state_next = ST_DRAIN;
      ST_DRAIN:    if (w_drain_done) w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
    if (w_err) w_state_next = ST_IDLE;
  end

  // FSM outputs: busy level and the end-of-frame event that fires done
  always_comb begin
    w_busy   = (r_state != ST_IDLE);
    w_finish = w_err || ((r_state == ST_DRAIN) && w_drain_done);
  end

  // Pixel packer: lane 0 is the first pixel, completed word staged one cycle
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      r_base     <= '0;
      r_cap_idx  <= '0;
      r_byte_cnt <= '0;
      r_pack     <= '0;
      r_word_vld <= 1'b0;
      r_word_dat <= '0;
      r_word_adr <= '0;
    end else if (w_start_accept) begin
      r_base     <= cfg_base_addr;
      r_cap_idx  <= '0;
      r_byte_cnt <= '0;
      r_pack     <= '0;
      r_word_vld <= 1'b0;
    end else begin
      r_word_vld <= w_word_done && !w_err;
      if (w_sof_take) begin
        r_pack     <= {16'h0000, pix_data};
        r_byte_cnt <= 2'd1;
      end else if (w_pix_take) begin
        if (r_byte_cnt == 2'd3) begin
          r_word_dat <= {pix_data, r_pack};
          r_word_adr <= w_word_adr;
          r_cap_idx  <= r_cap_idx + IDXW'(1);
          r_byte_cnt <= 2'd0;
        end else begin
          case (r_byte_cnt)
            2'd0:    r_pack[7:0]   <= pix_data;
            2'd1:    r_pack[15:8]  <= pix_data;
            default: r_pack[23:16] <= pix_data;
          endcase
          r_byte_cnt <= r_byte_cnt + 2'd1;
        end
      end
    end
  end

  // Sticky status flags (cleared by an accepted start) and the done pulse
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      r_overflow <= 1'b0;
      r_bus_err  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_start_accept) begin
        r_overflow <= 1'b0;
        r_bus_err  <= 1'b0;
      end else begin
        if (w_drop) r_overflow <= 1'b1;
        if (w_err)  r_bus_err  <= 1'b1;
      end
      r_done <= w_finish;
    end
  end

  // Wishbone burst writer: CYC and STB move together; RTY re-presents the head
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      r_cyc    <= 1'b0;
      r_resume <= 1'b0;
      r_beats  <= '0;
    end else if (w_err) begin
      r_cyc    <= 1'b0;
      r_resume <= 1'b0;
      r_beats  <= '0;
    end else if (r_cyc) begin
      if (w_ack) begin
        if (w_last_beat) begin
          r_cyc   <= 1'b0;
          r_beats <= '0;
        end else begin
          r_beats <= r_beats + BEATW'(1);
        end
      end else if (w_rty) begin
        r_cyc    <= 1'b0;
        r_resume <= 1'b1;
      end
    end else if (w_start_cyc) begin
      r_cyc    <= 1'b1;
      r_resume <= 1'b0;
    end
  end

  video_in_word_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .p_clk       (p_clk),
    .p_resetn    (p_resetn),
    .i_flush     (w_err),
    .i_push      (r_word_vld),
    .i_push_data ({r_word_adr, r_word_dat}),
    .i_pop       (w_ack),
    .o_head      (w_head),
    .o_count     (w_fifo_count),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  assign p_wb_CYC_O = r_cyc;
  assign p_wb_STB_O = r_cyc;
  assign p_wb_WE_O  = r_cyc;
  assign p_wb_SEL_O = r_cyc ? c_SEL_ALL : 4'h0;
  assign p_wb_ADR_O = r_cyc ? w_head[63:32] : 32'h0;
  assign p_wb_DAT_O = r_cyc ? w_head[31:0]  : 32'h0;

  assign busy     = w_busy;
  assign done     = r_done;
  assign overflow = r_overflow;
  assign bus_err  = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_video_in_dma_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_in_dma_writer
// Description : Self-checking bench for video_in_dma_writer. A Wishbone slave
//               model records every acknowledged write; expected words come
//               from the pixel list the bench drove (four pixels per word,
//               first pixel in the low byte, address base + 4*index).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_in_dma_writer;

  localparam int FW = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] cfg_base_addr;
  logic        cfg_start;
  logic        pix_valid;
  logic        pix_sof;
  logic [7:0]  pix_data;
  logic [31:0] adr_o, dat_o;
  logic [31:0] dat_i;
  logic [3:0]  sel_o;
  logic        cyc_o, stb_o, we_o;
  logic        ack_i, err_i, rty_i;
  logic        busy, done, overflow, bus_err;

  always #5 clk = ~clk;

  video_in_dma_writer #(
    .FRAME_WORDS (FW),
    .BURST_LEN   (4),
    .FIFO_DEPTH  (8)
  ) dut (
    .p_clk         (clk),
    .p_resetn      (rstn),
    .cfg_base_addr (cfg_base_addr),
    .cfg_start     (cfg_start),
    .pix_valid     (pix_valid),
    .pix_sof       (pix_sof),
    .pix_data      (pix_data),
    .p_wb_ADR_O    (adr_o),
    .p_wb_DAT_O    (dat_o),
    .p_wb_DAT_I    (dat_i),
    .p_wb_SEL_O    (sel_o),
    .p_wb_CYC_O    (cyc_o),
    .p_wb_STB_O    (stb_o),
    .p_wb_WE_O     (we_o),
    .p_wb_ACK_I    (ack_i),
    .p_wb_ERR_I    (err_i),
    .p_wb_RTY_I    (rty_i),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .bus_err       (bus_err)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Slave / monitor state
  logic [31:0] wr_adr[$];
  logic [31:0] wr_dat[$];
  int          bursts[$];
  int          cur_acks = 0;
  logic        prev_cyc = 1'b0;
  int          n_done = 0;
  int          done_base = 0;
  int          delay_left = 0;
  int          max_delay = 0;
  bit          err_en = 0, err_watch = 0;
  logic [31:0] err_adr = 0;
  logic        err_cyc_after = 0, err_done_after = 0, err_busy_after = 0;
  bit          rty_en = 0, rty_watch = 0;
  logic [31:0] rty_adr = 0, rty_adr1 = 0, rty_dat1 = 0, rty_adr2 = 0, rty_dat2 = 0;
  int          rty_gap = 0;

  logic [7:0]  frame [64];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input int k);
    return {frame[4*k+3], frame[4*k+2], frame[4*k+1], frame[4*k]};
  endfunction

  // Wishbone slave and bus monitor, all sampling on the falling edge
  initial begin
    ack_i = 0; err_i = 0; rty_i = 0;
    forever begin
      @(negedge clk);
      ack_i = 0; err_i = 0; rty_i = 0;
      if (done) n_done++;
      if (prev_cyc && !cyc_o) begin
        bursts.push_back(cur_acks);
        cur_acks = 0;
      end
      if (err_watch) begin
        err_cyc_after  = cyc_o;
        err_done_after = done;
        err_busy_after = busy;
        err_watch      = 0;
      end
      if (rty_watch) begin
        if (!cyc_o) rty_gap++;
        else begin
          rty_adr2  = adr_o;
          rty_dat2  = dat_o;
          rty_watch = 0;
        end
      end
      prev_cyc = cyc_o;
      if (stb_o) begin
        if (delay_left > 0) delay_left--;
        else if (err_en && adr_o == err_adr) begin
          err_i = 1; err_en = 0; err_watch = 1;
        end else if (rty_en && adr_o == rty_adr) begin
          rty_i = 1; rty_en = 0; rty_watch = 1; rty_gap = 0;
          rty_adr1 = adr_o; rty_dat1 = dat_o;
        end else begin
          ack_i = 1;
          wr_adr.push_back(adr_o);
          wr_dat.push_back(dat_o);
          cur_acks++;
          delay_left = $urandom_range(0, max_delay);
        end
      end
    end
  end

  task automatic px(input logic v, input logic s, input logic [7:0] d);
    pix_valid = v; pix_sof = s; pix_data = d;
    @(negedge clk);
  endtask

  task automatic wait_done();
    int k = 0;
    while (n_done == done_base && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", n_done != done_base, 1);
    repeat (6) @(negedge clk);
  endtask

  task automatic run_frame(input logic [31:0] base, input int junk, input int max_gap,
                           input int extra, input bit inc_data, input bit mid_start);
    for (int i = 0; i < 64; i++) frame[i] = inc_data ? 8'(i) : 8'($urandom);
    wr_adr.delete(); wr_dat.delete(); bursts.delete(); cur_acks = 0;
    done_base = n_done;
    cfg_base_addr = base; cfg_start = 1;
    @(negedge clk);
    cfg_start = 0; cfg_base_addr = $urandom;
    for (int j = 0; j < junk; j++) begin
      if (j % 2 == 0) px(1'b1, 1'b0, 8'($urandom));
      else            px(1'b0, 1'b1, 8'($urandom));
    end
    px(1'b1, 1'b1, frame[0]);
    for (int i = 1; i < 64; i++) begin
      int g = $urandom_range(0, max_gap);
      repeat (g) px(1'b0, 1'($urandom), 8'($urandom));
      if (mid_start && i == 20) begin
        cfg_start = 1; cfg_base_addr = 32'h1234_5670;
      end
      px(1'b1, 1'($urandom), frame[i]);
      cfg_start = 0;
    end
    for (int j = 0; j < extra; j++) px(1'b1, 1'b1, 8'($urandom));
    pix_valid = 0; pix_sof = 0;
    wait_done();
  endtask

  task automatic check_frame(input logic [31:0] base, input bit full);
    int n = wr_adr.size();
    int prev = -1;
    if (full) chk("n_writes", n, FW);
    for (int k = 0; k < n; k++) begin
      logic [31:0] off = wr_adr[k] - base;
      int idx = int'(off >> 2);
      chk("wr_idx_ok", (off[1:0] == 2'b00) && (off < 32'(4*FW)) && (idx > prev), 1);
      if (off < 32'(4*FW)) chk("wr_data", wr_dat[k], exp_word(idx));
      prev = idx;
    end
    chk("overflow_flag", overflow, n < FW);
    chk("done_once", n_done - done_base, 1);
    chk("busy_end", busy, 0);
    chk("cyc_end", cyc_o, 0);
    chk("bus_err_clear", bus_err, 0);
  endtask

  initial begin
    logic [31:0] b;
    int          k;
    rstn = 0; cfg_base_addr = 0; cfg_start = 0;
    pix_valid = 0; pix_sof = 0; pix_data = 0; dat_i = 0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_cyc", {cyc_o, stb_o, we_o}, 0);
    chk("rst_adr", adr_o, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_sel", sel_o, 0);
    chk("rst_status", {busy, done, overflow, bus_err}, 0);
    rstn = 1;
    @(negedge clk);

    // nominal frame, continuous pixels
    run_frame(32'h8000_0000, 0, 0, 0, 1, 0);
    check_frame(32'h8000_0000, 1);
    chk("first_adr", wr_adr.size() > 0 ? wr_adr[0] : 32'hDEAD_BEEF, 32'h8000_0000);
    chk("first_dat", wr_dat.size() > 0 ? wr_dat[0] : 32'hDEAD_BEEF, 32'h0302_0100);
    chk("last_adr", wr_adr.size() == FW ? wr_adr[FW-1] : 32'hDEAD_BEEF, 32'h8000_003C);
    chk("last_dat", wr_dat.size() == FW ? wr_dat[FW-1] : 32'hDEAD_BEEF, 32'h3F3E_3D3C);
    chk("n_bursts", bursts.size(), 4);
    foreach (bursts[i]) chk("burst_len", bursts[i], 4);

    // pre-sof junk, gaps, trailing pixels
    run_frame(32'h8000_0000, 7, 3, 2, 1, 0);
    check_frame(32'h8000_0000, 1);

    // long ACK stall forces overflow
    delay_left = 40;
    run_frame(32'h4000_0100, 0, 0, 0, 0, 0);
    check_frame(32'h4000_0100, 0);
    chk("stall_overflow", overflow, 1);

    // single retry on word 5
    rty_adr = 32'h2000_0014; rty_en = 1;
    run_frame(32'h2000_0000, 2, 1, 0, 0, 0);
    check_frame(32'h2000_0000, 1);
    chk("rty_adr", rty_adr1, 32'h2000_0014);
    chk("rty_gap", rty_gap, 1);
    chk("rty_readr", rty_adr2, 32'h2000_0014);
    chk("rty_redat", rty_dat2, exp_word(5));
    chk("rty_dat_orig", rty_dat1, exp_word(5));

    // bus error on word 2
    err_adr = 32'h1000_0008; err_en = 1;
    run_frame(32'h1000_0000, 0, 0, 0, 0, 0);
    chk("err_cyc_next", err_cyc_after, 0);
    chk("err_done", err_done_after, 1);
    chk("err_busy", err_busy_after, 0);
    chk("err_flag", bus_err, 1);
    chk("err_writes", wr_adr.size(), 2);
    chk("err_done_once", n_done - done_base, 1);
    run_frame(32'h1000_0000, 1, 1, 0, 0, 0);
    check_frame(32'h1000_0000, 1);

    // reset in the middle of a burst
    cfg_base_addr = 32'h0000_1000; cfg_start = 1;
    @(negedge clk);
    cfg_start = 0;
    k = 0;
    px(1'b1, 1'b1, 8'h00);
    while (!cyc_o && k < 200) begin
      px(1'b1, 1'b0, 8'(k));
      k++;
    end
    chk("rst_burst_seen", cyc_o, 1);
    #2 rstn = 0;
    #1;
    chk("arst_cyc", {cyc_o, stb_o, we_o}, 0);
    chk("arst_bus", {adr_o, sel_o}, 0);
    chk("arst_status", {busy, done, overflow, bus_err}, 0);
    pix_valid = 0;
    repeat (2) @(negedge clk);
    rstn = 1;
    @(negedge clk);
    wr_adr.delete(); wr_dat.delete();
    px(1'b1, 1'b1, 8'h55);
    repeat (40) px(1'b1, 1'b0, 8'($urandom));
    pix_valid = 0;
    repeat (4) @(negedge clk);
    chk("no_start_writes", wr_adr.size(), 0);
    chk("no_start_busy", busy, 0);

    // wrap across 2^32 with an ignored mid-capture start
    run_frame(32'hFFFF_FFF8, 3, 1, 2, 0, 1);
    check_frame(32'hFFFF_FFF8, 1);
    chk("wrap_adr2", wr_adr.size() > 2 ? wr_adr[2] : 32'hDEAD_BEEF, 32'h0000_0000);

    // randomized frames with random bases and ACK latency
    for (int it = 0; it < 4; it++) begin
      b = {$urandom, 2'b00};
      b = {b[31:2], 2'b00};
      max_delay = $urandom_range(0, 2);
      run_frame(b, $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
      check_frame(b, 0);
    end
    max_delay = 0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
